ysyx_isram: RTL

YSYX_ISRAM -- requirements
Module: ysyx_isram

---
 rtl/ysyx_pkg.sv | 19 +
 rtl/ysyx_isram_array.sv | 31 +++
 rtl/ysyx_isram.sv | 118 +++++++++++
 3 files changed

// File: rtl/ysyx_pkg.sv
// Shared definitions for the ysyx instruction SRAM: FSM encoding, default
// base address and the address-decode fault helper.
package ysyx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } isram_state_e;

    localparam logic [31:0] ISRAM_ADDR_BASE = 32'h8000_0000;

    // off is (addr - base), so an address below base wraps to a huge offset
    // and is rejected by the same range test as one above the window.
    function automatic logic addr_fault(input logic [31:0] off, input int unsigned depth_log2);
        return (off[1:0] != 2'b00) || ((off >> (depth_log2 + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/ysyx_isram_array.sv
// Word-wide storage with synchronous write and enabled synchronous read.
// A read and write to the same word on one edge return the old contents.
module ysyx_isram_array #(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] rdata_reg;

    // The read register only loads on re, so it holds the word while the
    // response is stalled; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/ysyx_isram.sv
// Instruction SRAM responder: one outstanding fetch, fixed wait latency,
// registered response with access-fault reporting, plus a preload port.
module ysyx_isram
    import ysyx_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE  = ISRAM_ADDR_BASE,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic        rerr,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    isram_state_e state_reg, state_next;
    logic [3:0]   cnt_reg, cnt_next;
    logic [31:0]  addr_reg;
    logic         rerr_reg;
    logic         enter_resp;
    logic         accept;

    logic [31:0]  rd_addr, rd_off, ld_off;
    logic         rd_fault, ld_fault;
    logic [31:0]  arr_rdata;

    // With zero latency RESP is entered on the accept edge itself, before
    // addr_reg has been loaded, so the read address bypasses the latch.
    assign rd_addr  = (state_reg == ST_IDLE) ? araddr : addr_reg;
    assign rd_off   = rd_addr - ADDR_BASE;
    assign rd_fault = addr_fault(rd_off, DEPTH_LOG2);
    assign ld_off   = ld_addr - ADDR_BASE;
    assign ld_fault = addr_fault(ld_off, DEPTH_LOG2);

    ysyx_isram_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (ld_en && !ld_fault),
        .waddr (ld_off[DEPTH_LOG2+1:2]),
        .wdata (ld_data),
        .re    (enter_resp),
        .raddr (rd_off[DEPTH_LOG2+1:2]),
        .rdata (arr_rdata)
    );

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_resp = 1'b0;
        accept     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (arvalid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_RESP: begin
                if (rready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 32'd0;
            rerr_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg <= araddr;
            end
            if (enter_resp) begin
                rerr_reg <= rd_fault;
            end
        end
    end

    assign arready = (state_reg == ST_IDLE);
    assign rvalid  = (state_reg == ST_RESP);
    assign rerr    = rvalid && rerr_reg;
    assign rdata   = (rvalid && !rerr_reg) ? arr_rdata : 32'd0;

endmodule
